// File: rtl/add_serial_if.sv
// Requester-side handshake and result bus of the bit-serial adder.
interface add_serial_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    // Requester drives the operands and start, consumes status and result
    modport master (
        output start, a, b, c_in,
        input  busy, done, sum, c_out
    );

    // The adder sequencer sees the mirror image
    modport slave (
        input  start, a, b, c_in,
        output busy, done, sum, c_out
    );
endinterface

// File: rtl/add_serial_ctrl.sv
// Bit-serial adder sequencer: one full-add slice reused for WIDTH cycles,
// LSB first, with IDLE/RUN/DONE control and a registered result.
module add_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    add_serial_if.slave  bus
);
    // Counter holds 0..WIDTH so it never wraps inside an operation
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] sum_sh_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             c_out_reg;
    logic [CW-1:0]    cnt_reg;

    logic             accept;
    logic             last_bit;

    // Full-add slice built from two half adders and an OR
    logic             ha1_s;
    logic             ha1_c;
    logic             ha2_c;
    logic             s_bit;
    logic             carry_next;

    // Sum shift register after inserting this cycle's bit at the MSB end
    logic [WIDTH-1:0] sum_sh_next;

    // A new request is taken whenever the slice is not busy
    assign accept   = bus.start && (state_reg != RUN);
    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    assign ha1_s      = a_sh_reg[0] ^ b_sh_reg[0];
    assign ha1_c      = a_sh_reg[0] & b_sh_reg[0];
    assign s_bit      = ha1_s ^ carry_reg;
    assign ha2_c      = ha1_s & carry_reg;
    assign carry_next = ha1_c | ha2_c;

    // Shift right by one and drop the new bit into the MSB; empty loop when WIDTH==1
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_sum_shift
            assign sum_sh_next[gi] = sum_sh_reg[gi + 1];
        end
    endgenerate
    assign sum_sh_next[WIDTH-1] = s_bit;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_bit)  state_next = DONE;
            DONE:    state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded straight from the state
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state_reg)
            RUN:     bus.busy = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    // Operand shifting, carry, bit counter and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            sum_sh_reg <= '0;
            sum_reg    <= '0;
            carry_reg  <= 1'b0;
            c_out_reg  <= 1'b0;
            cnt_reg    <= '0;
        end else if (accept) begin
            a_sh_reg   <= bus.a;
            b_sh_reg   <= bus.b;
            carry_reg  <= bus.c_in;
            sum_sh_reg <= '0;
            cnt_reg    <= '0;
        end else if (state_reg == RUN) begin
            a_sh_reg   <= a_sh_reg >> 1;
            b_sh_reg   <= b_sh_reg >> 1;
            carry_reg  <= carry_next;
            sum_sh_reg <= sum_sh_next;
            cnt_reg    <= cnt_reg + CW'(1);
            // The last bit goes straight into the result so done lines up with it
            if (last_bit) begin
                sum_reg   <= sum_sh_next;
                c_out_reg <= carry_next;
            end
        end
    end

    assign bus.sum   = sum_reg;
    assign bus.c_out = c_out_reg;
endmodule
